// File: rtl/counter_pkg.sv
// Shared types and defaults for the prescaled up counter.
// Holds the FSM state encoding and the default WIDTH/PRESC values.
package counter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRESC = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/prescaler.sv
// Divides qualified enable cycles: tick on every PRESC-th en cycle.
// Ports: clock, reset (sync, high), restart (zero count), en, tick.
module prescaler
  import counter_pkg::*;
#(
  parameter int PRESC = DEF_PRESC
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

  logic [CW-1:0] cnt;

  // Tick is combinational so the parent sees it in the same cycle
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/up_counter.sv
// Prescaled up counter with loadable target, one-shot or auto-reload.
// Ports: clock, reset, in, latch, clear, inc, mode -> counter, max, done.
module up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRESC = DEF_PRESC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             latch,
  input  logic             clear,
  input  logic             inc,
  input  logic             mode,
  output logic [WIDTH-1:0] counter,
  output logic             max,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] nxt;
  logic             en;
  logic             tick;
  logic             restart;

  // latch/clear win over inc, so they also block prescaler advance
  assign en      = inc && (state == RUN) && !latch && !clear;
  assign restart = latch || clear;
  assign nxt     = counter + WIDTH'(1);
  assign max     = (counter == target) && (state != IDLE);

  prescaler #(
    .PRESC(PRESC)
  ) u_pre (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .en     (en),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      target  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (latch) begin
        target  <= in;
        counter <= '0;
        state   <= (in == '0) ? HOLD : RUN;
      end else if (clear && state != IDLE) begin
        counter <= '0;
        state   <= (target == '0) ? HOLD : RUN;
      end else if (tick) begin
        if (counter != target) begin
          counter <= nxt;
          if (nxt == target) begin
            done <= 1'b1;
            if (!mode) state <= HOLD;
          end
        end else if (mode) begin
          counter <= '0;
        end else begin
          // Reached target under auto-reload, then switched to one-shot
          state <= HOLD;
        end
      end
    end
  end

endmodule

// File: doc/up_counter.md
UP_COUNTER -- requirements
Module: up_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and target width in bits (legal range 2..16).
REQ-002 Parameter PRESC, default 1, number of qualified inc cycles per count step (legal range 1..256).
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in  input  WIDTH  target value, captured on latch.
REQ-006 Port latch  input  1  load target from in and restart the count from 0.
REQ-007 Port clear  input  1  restart the count from 0 and keep the current target.
REQ-008 Port inc  input  1  count-enable, qualified by the prescaler.
REQ-009 Port mode  input  1  0 = one-shot (stop at target), 1 = auto-reload (wrap to 0 after target).
REQ-010 Port counter  output  WIDTH  current count value, registered.
REQ-011 Port max  output  1  combinational; 1 when counter == target and state is not IDLE.
REQ-012 Port done  output  1  registered; single-cycle pulse when an increment makes counter equal target.

Function
REQ-013 The FSM SHALL have states IDLE (no target loaded), RUN (counting), and HOLD (one-shot target reached).
REQ-014 latch SHALL set target to in, counter to 0, and the prescaler to 0, then go to RUN, or to HOLD if in == 0, from any state.
REQ-015 clear SHALL set counter and the prescaler to 0 and go to RUN (HOLD if target == 0); clear in IDLE SHALL be ignored.
REQ-016 Priority SHALL be reset > latch > clear > inc; a cycle with latch and inc SHALL NOT increment.
REQ-017 In IDLE and HOLD, inc SHALL be ignored and the prescaler SHALL NOT advance.
REQ-018 In RUN, each inc=1 cycle SHALL advance the prescaler; tick SHALL occur on the PRESC-th such cycle, after which the prescaler returns to 0.
REQ-019 With PRESC = 1, tick SHALL equal inc, giving a count on every inc cycle.
REQ-020 Each tick in RUN with counter != target SHALL load counter+1 at that edge.
REQ-021 When that increment yields target, done SHALL be 1 for exactly the following cycle, and in mode 0 the state SHALL become HOLD on the same edge.
REQ-022 In mode 1, a tick with counter == target SHALL load counter = 0, stay in RUN, and not assert done.
REQ-023 Changing mode while counting SHALL take effect on the next tick; a mode change in HOLD SHALL NOT leave HOLD.
REQ-024 Arithmetic SHALL be WIDTH-bit unsigned with no overflow path, since counter never exceeds target; a target of all ones SHALL be legal.
REQ-025 Latency SHALL be 1 clock from a qualifying input to counter, done, and state; max SHALL follow counter with no extra delay.

Reset
REQ-026 reset SHALL set counter = 0, target = 0, prescaler = 0, done = 0, and state = IDLE; max SHALL therefore read 0.
REQ-027 reset asserted mid-count SHALL abandon the count with no done pulse, and it SHALL override latch, clear, and inc in the same cycle.

Structure
REQ-028 The FSM state encoding (IDLE, RUN, HOLD) and the WIDTH/PRESC default constants SHALL live in the shared package counter_pkg.
REQ-029 The prescaler SHALL be a sub-module named prescaler (ports clock, reset, restart, en, tick), instantiated once.
REQ-030 counter, target, state, and done SHALL each be held in a single register; max SHALL be pure combinational logic.

Verification
REQ-031 Test 1 (WIDTH=4, PRESC=1, mode 0): reset, latch in=5, inc held -> counter 1..5, done pulses once on the cycle counter==5, then HOLD with counter stuck at 5 and max=1.
REQ-032 Test 2 (mode 1): latch in=3, inc held for 10 cycles -> counter 1,2,3,0,1,2,3,0,1,2 and done pulses on both 3s only.
REQ-033 Test 3 (PRESC=3): latch in=2, inc held -> counter steps to 1 after 3 inc cycles and to 2 after 6; deasserting inc mid-period pauses the prescaler.
REQ-034 Test 4: latch in=0 -> next cycle HOLD, max=1, done=0, and inc has no effect; latch in=15 -> counts to 15 without wrap, done=1.
REQ-035 Test 5: latch and inc in the same cycle -> counter=0 with no increment; clear during a count at 4 with target 9 -> counter=0, target stays 9, counting resumes.
REQ-036 Test 6: reset asserted at counter=6, target=8 -> next cycle counter=0, IDLE, max=0, no done pulse; inc ignored until the next latch.
